// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: per-register outstanding-write counters driving ID stall/issue.
// Optional macro HAZARD_WB_BYPASS_EN: a final WB retire clears the hazard in the same cycle.
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic            id_reg_write,
  input  logic            flush,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd_addr,
  output logic            Stall,
  output logic            issue,
  output logic            busy,
  output logic [NREG-1:0] pending,
  output logic            err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_underflow_q;
  logic             err_underflow_d;

  logic raw1;
  logic raw2;
  logic sat;
  logic inc;
  logic dec;
  logic same;

  // Hazard terms and the stall/issue decision.
  always_comb begin
    raw1 = (id_rs1_addr != 5'd0) &&
           (cnt_q[id_rs1_addr] != CNT_ZERO);
    raw2 = (id_rs2_addr != 5'd0) &&
           (cnt_q[id_rs2_addr] != CNT_ZERO);
`ifdef HAZARD_WB_BYPASS_EN
    if (wb_reg_write && wb_rd_addr == id_rs1_addr &&
        cnt_q[id_rs1_addr] == CNT_ONE)
      raw1 = 1'b0;
    if (wb_reg_write && wb_rd_addr == id_rs2_addr &&
        cnt_q[id_rs2_addr] == CNT_ONE)
      raw2 = 1'b0;
`endif
    sat   = id_reg_write && (id_rd_addr != 5'd0) &&
            (cnt_q[id_rd_addr] == CNT_MAX);
    Stall = id_valid && !flush && (raw1 || raw2 || sat);
    issue = id_valid && !flush && !Stall;
  end

  // Counter next-state: inc from issue, dec from WB retire.
  always_comb begin
    inc  = issue && id_reg_write && (id_rd_addr != 5'd0);
    dec  = wb_reg_write && (wb_rd_addr != 5'd0);
    same = inc && dec && (id_rd_addr == wb_rd_addr);
    err_underflow_d = err_underflow_q;
    cnt_d[0] = CNT_ZERO;
    for (int i = 1; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!same) begin
        if (inc && id_rd_addr == 5'(i))
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        if (dec && wb_rd_addr == 5'(i)) begin
          if (cnt_q[i] == CNT_ZERO)
            err_underflow_d = 1'b1;
          else
            cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end
    end
  end

  // Registered view of outstanding writes.
  always_comb begin
    pending = '0;
    for (int i = 1; i < NREG; i++)
      pending[i] = (cnt_q[i] != CNT_ZERO);
    busy          = |pending;
    err_underflow = err_underflow_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        cnt_q[i] <= CNT_ZERO;
      err_underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++)
        cnt_q[i] <= cnt_d[i];
      err_underflow_q <= err_underflow_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Expected values are hand-derived per vector.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write;
  logic        flush;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic        Stall;
  logic        issue;
  logic        busy;
  logic [31:0] pending;
  logic        err_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_rd_addr    (id_rd_addr),
    .id_reg_write  (id_reg_write),
    .flush         (flush),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .Stall         (Stall),
    .issue         (issue),
    .busy          (busy),
    .pending       (pending),
    .err_underflow (err_underflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd,
                     input logic rw, input logic fl,
                     input logic wbw, input logic [4:0] wbrd);
    id_valid     = v;
    id_rs1_addr  = rs1;
    id_rs2_addr  = rs2;
    id_rd_addr   = rd;
    id_reg_write = rw;
    flush        = fl;
    wb_reg_write = wbw;
    wb_rd_addr   = wbrd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    reset = 1'b1;
    step();

    drv(1, 5, 6, 0, 0, 0, 0, 0);
    chk("idle_stall", 32'(Stall), 32'd0);
    chk("idle_issue", 32'(issue), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    drv(1, 0, 0, 3, 1, 0, 0, 0);
    chk("raw_iss_x3", 32'(issue), 32'd1);
    step();
    drv(1, 3, 0, 0, 0, 0, 0, 0);
    chk("raw_stall", 32'(Stall), 32'd1);
    chk("raw_issue", 32'(issue), 32'd0);
    chk("raw_pend", pending, 32'h8);
    chk("raw_busy", 32'(busy), 32'd1);
    step();
    chk("raw_hold", 32'(Stall), 32'd1);
    drv(1, 3, 0, 0, 0, 0, 1, 3);
`ifdef HAZARD_WB_BYPASS_EN
    chk("raw_retire_cyc", 32'(Stall), 32'd0);
`else
    chk("raw_retire_cyc", 32'(Stall), 32'd1);
`endif
    step();
    drv(1, 3, 0, 0, 0, 0, 0, 0);
    chk("raw_after", 32'(Stall), 32'd0);
    chk("raw_pend0", pending, 32'd0);

    drv(1, 0, 0, 0, 1, 0, 0, 0);
    chk("x0_stall", 32'(Stall), 32'd0);
    step();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_stall2", 32'(Stall), 32'd0);
    chk("x0_pend", pending, 32'd0);

    for (int k = 0; k < 3; k++) begin
      drv(1, 0, 0, 7, 1, 0, 0, 0);
      chk("sat_iss", 32'(issue), 32'd1);
      step();
    end
    drv(1, 0, 0, 7, 1, 0, 0, 0);
    chk("sat_stall", 32'(Stall), 32'd1);
    chk("sat_pend", pending, 32'h80);
    drv(0, 0, 0, 7, 1, 0, 0, 0);
    chk("sat_novalid", 32'(Stall), 32'd0);
    drv(1, 0, 0, 7, 1, 0, 1, 7);
    chk("sat_retire_cyc", 32'(Stall), 32'd1);
    step();
    drv(1, 0, 0, 7, 1, 0, 0, 0);
    chk("sat_4th_iss", 32'(issue), 32'd1);
    step();
    chk("sat_full_again", 32'(Stall), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 0, 0, 0, 0, 1, 7);
      step();
    end
    idle();
    chk("sat_drained", pending, 32'd0);
    chk("sat_noerr", 32'(err_underflow), 32'd0);

    drv(1, 0, 0, 9, 1, 0, 0, 0);
    step();
    drv(1, 0, 0, 9, 1, 0, 1, 9);
    chk("same_iss", 32'(issue), 32'd1);
    step();
    drv(1, 0, 0, 10, 1, 0, 0, 0);
    step();
    step();
    drv(1, 0, 0, 9, 1, 0, 1, 10);
    chk("mix_iss", 32'(issue), 32'd1);
    step();
    drv(0, 0, 0, 0, 0, 0, 1, 10);
    step();
    idle();
    chk("mix_x10_1", pending, 32'h200);
    drv(0, 0, 0, 0, 0, 0, 1, 9);
    step();
    idle();
    chk("mix_x9_2", pending, 32'h200);
    drv(0, 0, 0, 0, 0, 0, 1, 9);
    step();
    idle();
    chk("mix_clear", pending, 32'd0);
    chk("mix_noerr", 32'(err_underflow), 32'd0);

    drv(1, 13, 0, 13, 1, 0, 0, 0);
    chk("selfdep_iss", 32'(issue), 32'd1);
    step();
    drv(0, 0, 0, 0, 0, 0, 1, 13);
    step();

    drv(1, 0, 0, 4, 1, 0, 0, 0);
    step();
    drv(1, 4, 0, 12, 1, 1, 0, 0);
    chk("flush_stall", 32'(Stall), 32'd0);
    chk("flush_issue", 32'(issue), 32'd0);
    step();
    idle();
    chk("flush_pend", pending, 32'h10);

    #2;
    reset = 1'b0;
    #1;
    chk("arst_pend", pending, 32'd0);
    step();
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 1, 4);
    step();
    idle();
    chk("uf_pend", pending, 32'd0);
    chk("uf_err", 32'(err_underflow), 32'd1);
    step();
    chk("uf_sticky", 32'(err_underflow), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard-detection responder for the in-order pipeline.
- The ID stage presents its source register addresses. This block answers with a Stall that holds IF/ID and turns the issued EX/MEM/WB control into NOP.
- Per-register counters track outstanding writes. A counter increments when ID issues an instruction that writes rd, and decrements when WB retires that write.
- Sits beside the ID stage. Its inputs come from ID decode and the WB write port; its Stall output feeds the pipeline registers and the ID control mux.

Parameters:
- NREG, 32, number of architectural registers tracked; x0 is never tracked.
- CNT_W, 2, width of each outstanding-write counter; maximum in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state when 0.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- id_rs1_addr  in  5  source 1 address from ID.
- id_rs2_addr  in  5  source 2 address from ID; 0 when the instruction uses an immediate as operand B.
- id_rd_addr  in  5  destination address from ID.
- id_reg_write  in  1  ID instruction writes rd.
- flush  in  1  ID instruction is squashed this cycle (taken branch/jump resolved downstream).
- wb_reg_write  in  1  WB writes the register file this cycle.
- wb_rd_addr  in  5  WB destination address.
- Stall  out  1  hold IF/ID and inject NOP controls into ID/EX.
- issue  out  1  ID instruction advances into EX this cycle.
- busy  out  1  at least one write is outstanding.
- pending  out  NREG  bit i = counter i nonzero (bit 0 always 0).
- err_underflow  out  1  sticky: a WB retire arrived for a register with counter 0.

Behaviour:
- Reset (reset=0, asynchronous): all counters and err_underflow cleared. Consequently Stall=0, issue=0, busy=0, pending=0.
- Hazard terms, all combinational from current counters and inputs:
  - raw1 = id_rs1_addr!=0 and cnt[id_rs1_addr]!=0.
  - raw2 = id_rs2_addr!=0 and cnt[id_rs2_addr]!=0.
  - sat = id_reg_write and id_rd_addr!=0 and cnt[id_rd_addr]==max.
- Stall = id_valid & ~flush & (raw1|raw2|sat).
- issue = id_valid & ~flush & ~Stall.
- Zero-latency stall: Stall asserts in the same cycle the hazard becomes visible. When the blocking counter reaches 0, Stall drops with no extra cycle, subject to the Optional Feature.
- Counter update at the rising edge:
  - inc = issue & id_reg_write & id_rd_addr!=0 applies to cnt[id_rd_addr].
  - dec = wb_reg_write & wb_rd_addr!=0 applies to cnt[wb_rd_addr].
  - Both targeting the same register: counter unchanged.
  - Different registers: both apply.
- Underflow: dec on a counter that is 0 leaves it at 0 and sets err_underflow, which holds until reset. This is the normal case for a retire that was in flight when reset was asserted.
- Overflow is impossible: sat forces a stall before any counter exceeds max.
- flush has priority over everything: no stall, no issue, no counter increment. Retires still decrement.
- id_valid=0: Stall=0, issue=0, no increment.
- A self-dependency (rd equal to rs1) is checked against the count before increment only; it never self-blocks.
- busy = OR of pending; pending and busy reflect registered state only.

Optional Feature:
- Macro HAZARD_WB_BYPASS_EN.
- Defined: a source is not hazardous when its counter equals 1 and WB retires that same register this cycle. The register file has write-through, so the read sees the new value and the stall drops one cycle earlier.
- Undefined: raw1/raw2 depend on counters only, and the stall releases the cycle after the final retire.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release; id_valid=1, rs1=5, rs2=6, no writes pending -> Stall=0, issue=1, busy=0, pending=0.
- RAW stall: issue rd=3 with reg_write; next cycle ID rs1=3 -> Stall=1 and pending[3]=1 until WB retires x3.
  - Retire at cycle 4 with bypass -> Stall=0 at cycle 4.
  - Without bypass -> Stall=0 at cycle 5.
- x0 and immediate: issue rd=0 reg_write=1, then rs1=0, rs2=0 -> never Stall, pending stays 0.
- Saturation (CNT_W=2): issue three writes to x7 with no retire -> cnt=3. A fourth write to x7 -> Stall=1. One retire of x7 -> fourth issues, cnt=3.
- Simultaneous inc and dec on x9 with cnt=1 -> cnt stays 1. Inc x9 with dec x10 (cnt 2) in the same cycle -> x9=2, x10=1.
- Flush and reset mid-operation:
  - flush=1 with a hazard present -> Stall=0, issue=0, no increment.
  - Assert reset with x4 pending, release, then WB retires x4 -> counter stays 0 and err_underflow=1.
